// File: rtl/diffeq_host_pkg.sv
// Shared types and default sizes for the diffeq solver host controller.
package diffeq_host_pkg;

  localparam int unsigned DIFFEQ_W     = 32;
  localparam int unsigned ITER_W_DEF   = 16;
  localparam int unsigned MAX_ITER_DEF = 65535;

  // Controller phases around one solver job.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPTURE,
    RESULT
  } state_t;

endpackage

// File: rtl/diffeq_shadow_x.sv
// Shadow copy of the solver x-progression plus a saturating iteration counter.
// done_c is high once shadow_x is no longer below the limit.
module diffeq_shadow_x
  import diffeq_host_pkg::*;
#(
  parameter int unsigned WIDTH  = DIFFEQ_W,
  parameter int unsigned ITER_W = ITER_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [WIDTH-1:0]  load_x,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  dx,
  output logic [ITER_W-1:0] iter,
  output logic              done_c
);

  localparam logic [ITER_W-1:0] ITER_MAX = {ITER_W{1'b1}};

  logic [WIDTH-1:0] shadow_x;

  // Loop exit condition, same unsigned compare the solver uses.
  assign done_c = !(shadow_x < a);

  // Track x and iteration count; the add wraps exactly like the solver.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_x <= '0;
      iter     <= '0;
    end else if (load) begin
      shadow_x <= load_x;
      iter     <= '0;
    end else if (step) begin
      shadow_x <= shadow_x + dx;
      if (iter != ITER_MAX) begin
        iter <= iter + ITER_W'(1);
      end
    end
  end

endmodule

// File: rtl/diffeq_host_ctrl.sv
// Host controller for the diffeq solver: takes one job at a time, drives the
// solver operands and reset, tracks its progress with a shadow x-progression
// and returns the captured outputs on a result stream.
// Optional macro DIFFEQ_HOST_TIMEOUT_EN: abort a job after MAX_ITER iterations
// and report it with res_err.
module diffeq_host_ctrl
  import diffeq_host_pkg::*;
#(
  parameter int unsigned WIDTH    = DIFFEQ_W,
  parameter int unsigned ITER_W   = ITER_W_DEF,
  parameter int unsigned MAX_ITER = MAX_ITER_DEF
) (
  input  logic              clk,
  input  logic              reset,
  // job stream
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [WIDTH-1:0]  job_x,
  input  logic [WIDTH-1:0]  job_y,
  input  logic [WIDTH-1:0]  job_u,
  input  logic [WIDTH-1:0]  job_a,
  input  logic [WIDTH-1:0]  job_dx,
  // result stream
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_x,
  output logic [WIDTH-1:0]  res_y,
  output logic [WIDTH-1:0]  res_u,
  output logic [ITER_W-1:0] res_iter,
  output logic              res_err,
  // solver port interface
  output logic              sv_reset,
  output logic [WIDTH-1:0]  sv_xin,
  output logic [WIDTH-1:0]  sv_yin,
  output logic [WIDTH-1:0]  sv_uin,
  output logic [WIDTH-1:0]  sv_a,
  output logic [WIDTH-1:0]  sv_dx,
  input  logic [WIDTH-1:0]  sv_xout,
  input  logic [WIDTH-1:0]  sv_yout,
  input  logic [WIDTH-1:0]  sv_uout
);

`ifdef DIFFEQ_HOST_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  state_t            state_q;
  state_t            state_d;
  logic              accept_c;
  logic              step_c;
  logic              capture_c;
  logic              expire_c;
  logic              done_c;
  logic              limit_hit_c;
  logic [ITER_W-1:0] iter;

  diffeq_shadow_x #(
    .WIDTH  (WIDTH),
    .ITER_W (ITER_W)
  ) u_shadow (
    .clk    (clk),
    .reset  (reset),
    .load   (accept_c),
    .step   (step_c),
    .load_x (job_x),
    .a      (sv_a),
    .dx     (sv_dx),
    .iter   (iter),
    .done_c (done_c)
  );

  // Iteration limit reached while the solver is still looping.
  assign limit_hit_c = TIMEOUT_EN && (iter == ITER_LIMIT);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-cycle datapath strobes.
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    step_c    = 1'b0;
    capture_c = 1'b0;
    expire_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (job_valid) begin
          accept_c = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        state_d = RUN;
      end
      RUN: begin
        if (done_c) begin
          state_d = CAPTURE;
        end else if (limit_hit_c) begin
          expire_c = 1'b1;
          state_d  = RESULT;
        end else begin
          step_c = 1'b1;
        end
      end
      CAPTURE: begin
        capture_c = 1'b1;
        state_d   = RESULT;
      end
      RESULT: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Job operand registers; held stable until the next acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sv_xin <= '0;
      sv_yin <= '0;
      sv_uin <= '0;
      sv_a   <= '0;
      sv_dx  <= '0;
    end else if (accept_c) begin
      sv_xin <= job_x;
      sv_yin <= job_y;
      sv_uin <= job_u;
      sv_a   <= job_a;
      sv_dx  <= job_dx;
    end
  end

  // Result capture: solver outputs on normal exit, zeros plus error on expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_x    <= '0;
      res_y    <= '0;
      res_u    <= '0;
      res_iter <= '0;
      res_err  <= 1'b0;
    end else if (capture_c) begin
      res_x    <= sv_xout;
      res_y    <= sv_yout;
      res_u    <= sv_uout;
      res_iter <= iter;
      res_err  <= 1'b0;
    end else if (expire_c) begin
      res_x    <= '0;
      res_y    <= '0;
      res_u    <= '0;
      res_iter <= ITER_LIMIT;
      res_err  <= 1'b1;
    end
  end

  // Handshake and solver reset decoded from the upcoming state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      job_ready <= 1'b1;
      res_valid <= 1'b0;
      sv_reset  <= 1'b1;
    end else begin
      job_ready <= (state_d == IDLE);
      res_valid <= (state_d == RESULT);
      sv_reset  <= (state_d == IDLE) || (state_d == CAPTURE) || (state_d == RESULT);
    end
  end

endmodule

// File: tb/tb_diffeq_host_ctrl.sv
// Bench for diffeq_host_ctrl with a behavioural model of the diffeq solver.
module tb_diffeq_host_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned IW = 16;
  localparam int          LAT_BUDGET = 200;

  typedef struct {
    logic [W-1:0]  x, y, u, a, dx;
    logic [W-1:0]  ex, ey, eu;
    logic [IW-1:0] eiter;
    logic          eerr;
    int            elat;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          job_valid, job_ready, res_valid, res_ready, res_err, sv_reset;
  logic [W-1:0]  job_x, job_y, job_u, job_a, job_dx;
  logic [W-1:0]  res_x, res_y, res_u;
  logic [IW-1:0] res_iter;
  logic [W-1:0]  sv_xin, sv_yin, sv_uin, sv_a, sv_dx;
  logic [W-1:0]  sv_xout, sv_yout, sv_uout;

  int n_total = 0;
  int n_pass  = 0;

  diffeq_host_ctrl #(.WIDTH(W), .ITER_W(IW), .MAX_ITER(8)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_x(job_x), .job_y(job_y), .job_u(job_u), .job_a(job_a), .job_dx(job_dx),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_x(res_x), .res_y(res_y), .res_u(res_u), .res_iter(res_iter), .res_err(res_err),
    .sv_reset(sv_reset),
    .sv_xin(sv_xin), .sv_yin(sv_yin), .sv_uin(sv_uin), .sv_a(sv_a), .sv_dx(sv_dx),
    .sv_xout(sv_xout), .sv_yout(sv_yout), .sv_uout(sv_uout)
  );

  always #5 clk = ~clk;

  // Solver model: sync active-high reset, loads on first free edge, iterates
  // while x < a, registers outputs on the exit edge.
  logic [W-1:0] m_x, m_y, m_u;
  logic         m_loaded;
  always_ff @(posedge clk) begin
    if (sv_reset) begin
      m_loaded <= 1'b0;
      m_x <= '0; m_y <= '0; m_u <= '0;
      sv_xout <= '0; sv_yout <= '0; sv_uout <= '0;
    end else if (!m_loaded) begin
      m_loaded <= 1'b1;
      m_x <= sv_xin; m_y <= sv_yin; m_u <= sv_uin;
    end else if (m_x < sv_a) begin
      m_x <= m_x + sv_dx;
      m_u <= m_u - 32'd3 * m_x * m_u * sv_dx - 32'd3 * m_y * sv_dx;
      m_y <= m_y + m_u * sv_dx;
    end else begin
      sv_xout <= m_x; sv_yout <= m_y; sv_uout <= m_u;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else n_pass++;
  endtask

  // Offer a job at a negedge and return just after the accepting edge.
  task automatic offer(input vec_t v, input bit keep_valid);
    @(negedge clk);
    job_x = v.x; job_y = v.y; job_u = v.u; job_a = v.a; job_dx = v.dx;
    job_valid = 1'b1;
    chk("job_ready_idle", W'(job_ready), W'(1));
    @(posedge clk);
    #1;
    if (!keep_valid) job_valid = 1'b0;
  endtask

  // Cycles from the accept edge until res_valid is seen (bounded).
  task automatic wait_result(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (!res_valid && cyc < LAT_BUDGET) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_result(input vec_t v, input int cyc, input string tag);
    chk({tag, "_lat"},   W'(cyc),      W'(v.elat));
    chk({tag, "_res_x"}, res_x,        v.ex);
    chk({tag, "_res_y"}, res_y,        v.ey);
    chk({tag, "_res_u"}, res_u,        v.eu);
    chk({tag, "_iter"},  W'(res_iter), W'(v.eiter));
    chk({tag, "_err"},   W'(res_err),  W'(v.eerr));
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_drained_valid"}, W'(res_valid), W'(0));
    chk({tag, "_drained_ready"}, W'(job_ready), W'(1));
  endtask

  vec_t vecs [5];

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   cyc;
    bit   ok;

    //           x            y   u   a            dx    ex           ey            eu            it err lat
    vecs[0] = '{32'd0,  32'd0, 32'd1, 32'd3,  32'd1, 32'd3,  32'hFFFFFFFD, 32'd19,       16'd3, 1'b0, 6};
    vecs[1] = '{32'd5,  32'd7, 32'd9, 32'd5,  32'd2, 32'd5,  32'd7,        32'd9,        16'd0, 1'b0, 3};
    vecs[2] = '{32'd0,  32'd0, 32'd0, 32'd4,  32'd2, 32'd4,  32'd0,        32'd0,        16'd2, 1'b0, 5};
    vecs[3] = '{32'd0,  32'd1, 32'd0, 32'd1,  32'd1, 32'd1,  32'd1,        32'hFFFFFFFD, 16'd1, 1'b0, 4};
    vecs[4] = '{32'd10, 32'd2, 32'd0, 32'd13, 32'd5, 32'd15, 32'd2,        32'hFFFFFFE2, 16'd1, 1'b0, 4};

    reset = 1'b0; job_valid = 1'b0; res_ready = 1'b0;
    job_x = '0; job_y = '0; job_u = '0; job_a = '0; job_dx = '0;
    repeat (3) @(negedge clk);
    chk("rst_job_ready", W'(job_ready), W'(1));
    chk("rst_sv_reset",  W'(sv_reset),  W'(1));
    chk("rst_res_valid", W'(res_valid), W'(0));
    chk("rst_res_err",   W'(res_err),   W'(0));
    chk("rst_res_iter",  W'(res_iter),  W'(0));
    chk("rst_sv_a",      sv_a,          W'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_sv_reset", W'(sv_reset), W'(1));

    // Table-driven jobs.
    for (int i = 0; i < 5; i++) begin
      offer(vecs[i], 1'b0);
      wait_result(cyc);
      check_result(vecs[i], cyc, $sformatf("vec%0d", i));
      drain($sformatf("vec%0d", i));
    end

    // Backpressure: result held, no acceptance, solver kept in reset.
    offer(vecs[1], 1'b0);
    wait_result(cyc);
    job_x = 32'd1; job_a = 32'd2; job_dx = 32'd1; job_valid = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!res_valid || res_x != 32'd5 || res_y != 32'd7 || res_u != 32'd9 ||
          res_iter != 16'd0 || job_ready || !sv_reset || sv_a != 32'd5) ok = 1'b0;
    end
    chk("bp_hold_stable", W'(ok), W'(1));
    job_valid = 1'b0;
    drain("bp");
    offer(vecs[3], 1'b0);
    wait_result(cyc);
    check_result(vecs[3], cyc, "bp_next");
    drain("bp_next");

    // Back-to-back with job_valid held high; second job differs from the first.
    offer(vecs[0], 1'b1);
    job_x = vecs[2].x; job_y = vecs[2].y; job_u = vecs[2].u;
    job_a = vecs[2].a; job_dx = vecs[2].dx;
    wait_result(cyc);
    check_result(vecs[0], cyc, "b2b_first");
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("b2b_ready_after_drain", W'(job_ready), W'(1));
    chk("b2b_valid_after_drain", W'(res_valid), W'(0));
    @(posedge clk);
    #1 job_valid = 1'b0;
    wait_result(cyc);
    check_result(vecs[2], cyc, "b2b_second");
    drain("b2b_second");

    // Reset mid-RUN after two iterations.
    v = '{32'd0, 32'd0, 32'd1, 32'd10, 32'd1, 32'd0, 32'd0, 32'd0, 16'd0, 1'b0, 0};
    offer(v, 1'b0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_sv_reset",  W'(sv_reset),  W'(1));
    chk("midrst_job_ready", W'(job_ready), W'(1));
    chk("midrst_res_valid", W'(res_valid), W'(0));
    chk("midrst_sv_a",      sv_a,          W'(0));
    chk("midrst_sv_dx",     sv_dx,         W'(0));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_no_result", W'(res_valid), W'(0));
    offer(vecs[4], 1'b0);
    wait_result(cyc);
    check_result(vecs[4], cyc, "after_rst");
    drain("after_rst");

    // DX=0 job: times out when the limit is built in, otherwise never finishes.
    v = '{32'd0, 32'd0, 32'd0, 32'd10, 32'd0, 32'd0, 32'd0, 32'd0, 16'd8, 1'b1, 10};
    offer(v, 1'b0);
`ifdef DIFFEQ_HOST_TIMEOUT_EN
    wait_result(cyc);
    check_result(v, cyc, "timeout");
    chk("timeout_sv_reset", W'(sv_reset), W'(1));
    drain("timeout");
`else
    repeat (100) @(negedge clk);
    chk("forever_no_valid", W'(res_valid), W'(0));
    chk("forever_busy",     W'(job_ready), W'(0));
    chk("forever_sv_run",   W'(sv_reset),  W'(0));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("forever_abort_ready", W'(job_ready), W'(1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/diffeq_host_ctrl.md
Name: diffeq_host_ctrl

Overview:
- Host-side controller that sits on the far side of the diffeq solver's port interface.
- Accepts operand jobs over a valid/ready stream and drives the solver's operand ports and its synchronous active-high reset.
- The solver has no done signal, so this block runs a shadow copy of the solver's x-progression to know the exact cycle its outputs become valid.
- It then captures the solver outputs and returns them on a valid/ready result stream. One job is in flight at a time.

Parameters:
- WIDTH, 32, datapath width of every operand and result.
- ITER_W, 16, width of the iteration counter.
- MAX_ITER, 65535, iteration limit used only when the timeout feature is compiled in.

Ports:
- clk  in  1  clock, shared with the solver.
- reset  in  1  asynchronous, active-low reset.
- job_valid  in  1  job offered.
- job_ready  out  1  job accepted when job_valid && job_ready.
- job_x, job_y, job_u, job_a, job_dx  in  WIDTH each  initial x, y, u, limit A, step DX.
- res_valid  out  1  result held until taken.
- res_ready  in  1  result consumer ready.
- res_x, res_y, res_u  out  WIDTH each  final solver values.
- res_iter  out  ITER_W  number of solver iterations executed.
- res_err  out  1  job aborted by timeout; always 0 without the optional feature.
- sv_reset  out  1  drives the solver's reset port (sync, active-high).
- sv_xin, sv_yin, sv_uin, sv_a, sv_dx  out  WIDTH each  drive solver Xinport/Yinport/Uinport/Aport/DXport.
- sv_xout, sv_yout, sv_uout  in  WIDTH each  from solver Xoutport/Youtport/Uoutport.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, sv_reset=1.
  - All sv_* operand outputs, res_* data, res_iter, shadow_x and the iteration count cleared to 0.
  - res_valid=0, res_err=0.
- The sv_* operand outputs come from job registers latched at acceptance. They stay stable from acceptance until the next acceptance.
- IDLE:
  - sv_reset=1; job_ready=1 only in IDLE.
  - On accept: latch operands, shadow_x<=job_x, iter<=0, go LOAD.
- LOAD (1 cycle):
  - sv_reset=0. The solver loads its inputs on the closing edge.
  - Go RUN.
- RUN:
  - sv_reset=0. Each cycle compare shadow_x < sv_a (unsigned WIDTH).
  - If true: shadow_x <= shadow_x + sv_dx (mod 2^WIDTH, identical wrap to the solver) and iter++.
  - If false: the solver registers its outputs on this edge; go CAPTURE.
- CAPTURE (1 cycle):
  - sv_reset=1, so the solver resets instead of reloading.
  - Latch sv_xout/sv_yout/sv_uout into res_*, latch res_iter=iter, res_err=0.
  - Go RESULT.
- RESULT:
  - res_valid=1, sv_reset=1, data held stable.
  - On res_valid && res_ready: go IDLE, res_valid=0.
- Latency: with N iterations, res_valid rises N+3 cycles after the accept edge (LOAD 1 + RUN N+1 + CAPTURE 1).
- Boundaries:
  - job_x >= job_a: N=0, result equals the job inputs, latency 3.
  - iter saturates at 2^ITER_W-1 and never wraps.
  - job_valid outside IDLE is ignored, with job_ready=0.
  - reset asserted mid-job aborts immediately. sv_reset=1 propagates asynchronously and the solver is reset on its next edge. No result is emitted.
  - res_ready already high on the first RESULT cycle: consumed in that cycle; next job accepted no earlier than the following cycle.

Optional Feature:
- Macro: DIFFEQ_HOST_TIMEOUT_EN.
- Defined:
  - In RUN, when iter == MAX_ITER and shadow_x < sv_a, skip CAPTURE and go straight to RESULT.
  - res_x/res_y/res_u=0, res_iter=MAX_ITER, res_err=1, sv_reset=1.
  - Guards against DX=0 or a wrapping DX.
- Undefined:
  - No limit; such a job runs forever until reset.
  - res_err is tied to 0.

Decomposition:
- Package diffeq_host_pkg holds the state enum (IDLE, LOAD, RUN, CAPTURE, RESULT), DIFFEQ_W=32 and ITER_W default.
- One natural sub-module, diffeq_shadow_x, containing shadow_x register, compare, add and iteration counter. It provides a done flag to the FSM.

Test Plan:
- Basic job: x=0, y=0, u=1, A=3, DX=1 -> res_x=3, res_y=0xFFFFFFFD, res_u=19, res_iter=3, res_valid 6 cycles after accept, bit-exact against the solver instance.
- Immediate-exit job: x=5, A=5, DX=2, y=7, u=9 -> res_x=5, res_y=7, res_u=9, res_iter=0, latency 3.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid -> result stable, job_ready=0, sv_reset=1 throughout. Release -> IDLE and next job accepted.
- Back-to-back jobs with job_valid held high -> second job accepted the cycle after the first result drains. Second result correct, proving the solver was reset between jobs.
- Reset asserted mid-RUN at iteration 2 -> all outputs return to reset values asynchronously, no res_valid. A fresh job after release completes correctly.
- With DIFFEQ_HOST_TIMEOUT_EN and MAX_ITER=8: x=0, A=10, DX=0 -> res_err=1, res_iter=8, data 0. Without the macro, the same job still has res_valid=0 after 100 cycles.
